// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, frame geometry, parity helper
// and the scan codes the game state machine consumes.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  localparam int unsigned FRAME_LEN  = 32'd11;
  localparam logic [3:0]  PARITY_IDX = 4'(FRAME_LEN - 32'd2);
  localparam logic [3:0]  STOP_IDX   = 4'(FRAME_LEN - 32'd1);

  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer for one PS/2 line, optionally followed by a run-length
// glitch filter; both stages rest at 1 (idle bus) out of reset.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 32'd4,
  parameter bit          FILTER_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level_o
);

  logic [1:0] sync_q, sync_d;

  // Synchronizer next value.
  always_comb begin
    sync_d = {sync_q[0], din};
  end

  // Synchronizer flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  if (FILTER_EN) begin : g_filter
    localparam int unsigned CNT_W = (FILTER_LEN > 32'd1) ? $clog2(FILTER_LEN) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 32'd1);

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = {CNT_W{1'b0}};
      if (sync_q[1] == filt_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(32'd1);
      end
    end

    // Filter state flops.
    always_ff @(posedge clk) begin
      if (rst) begin
        filt_q <= 1'b1;
        cnt_q  <= {CNT_W{1'b0}};
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign level_o = filt_q;
  end else begin : g_bypass
    assign level_o = sync_q[1];
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver producing the last two scan bytes for the game FSM.
// Define PS2_TIMEOUT_EN to add a mid-frame watchdog of TIMEOUT_CYCLES clk cycles.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 32'd4,
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] xkey,
  output logic        key_valid,
  output logic        frame_err
);

  logic       clk_lvl_s, data_lvl_s, fall_s, timeout_s;
  logic       clk_prev_q, clk_prev_d;
  ps2_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d, stop_q, stop_d;
  logic [15:0] xkey_q, xkey_d;
  logic       key_valid_q, key_valid_d, frame_err_q, frame_err_d;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b1)) u_clk_filter (
    .clk(clk), .rst(rst), .din(ps2_clk), .level_o(clk_lvl_s)
  );

  // The data line is only synchronized: it is sampled while the clock is settled.
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b0)) u_data_sync (
    .clk(clk), .rst(rst), .din(ps2_data), .level_o(data_lvl_s)
  );

  assign clk_prev_d = clk_lvl_s;
  assign fall_s     = clk_prev_q & ~clk_lvl_s;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  logic              edge_s;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  assign edge_s    = clk_prev_q ^ clk_lvl_s;
  assign timeout_s = (state_q == ST_SHIFT) && (wdog_q == WDOG_LIMIT) && !edge_s;

  // Watchdog restarts on every filtered clock edge and outside SHIFT.
  always_comb begin
    if ((state_q != ST_SHIFT) || edge_s) begin
      wdog_d = {WDOG_W{1'b0}};
    end else if (wdog_q != WDOG_LIMIT) begin
      wdog_d = wdog_q + WDOG_W'(32'd1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= {WDOG_W{1'b0}};
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  // No watchdog: a stalled frame waits forever; the parameter only keeps the interface uniform.
  assign timeout_s = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      stop_q      <= 1'b0;
      xkey_q      <= 16'h0000;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      stop_q      <= stop_d;
      xkey_q      <= xkey_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fall_s && !data_lvl_s) state_d = ST_SHIFT;
        else                       state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (timeout_s)                            state_d = ST_IDLE;
        else if (fall_s && bit_cnt_q == STOP_IDX) state_d = ST_CHECK;
        else                                      state_d = ST_SHIFT;
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bit capture and frame verdict; bit_cnt names the next bit expected (1..10).
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    stop_d      = stop_q;
    xkey_d      = xkey_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_s && !data_lvl_s) bit_cnt_d = 4'd1;
        else                       bit_cnt_d = 4'd0;
      end
      ST_SHIFT: begin
        if (timeout_s) begin
          bit_cnt_d   = 4'd0;
          frame_err_d = 1'b1;
        end else if (fall_s) begin
          if (bit_cnt_q <= 4'd8) begin
            shift_d   = {data_lvl_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == PARITY_IDX) begin
            parity_d  = data_lvl_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            stop_d    = data_lvl_s;
            bit_cnt_d = 4'd0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      ST_CHECK: begin
        bit_cnt_d = 4'd0;
        if (odd_parity_ok(shift_q, parity_q) && stop_q) begin
          xkey_d      = {xkey_q[7:0], shift_q};
          key_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: bit_cnt_d = 4'd0;
    endcase
  end

  assign xkey      = xkey_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: vector table, random frames against a
// frame-level model, and hand sequences for idle start, stall/timeout and reset.
module tb_ps2_key_receiver;
  import ps2_pkg::*;

  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 100;
  localparam int          HALF = 10;
  localparam int          LAT  = FL + 4; // 2 sync + FL filter + 2 to outputs

  logic        clk = 1'b0;
  logic        rst, ps2_clk, ps2_data;
  logic [15:0] xkey;
  logic        key_valid, frame_err;

  ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .xkey(xkey), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  typedef struct { int cyc; logic kv; logic fe; logic [15:0] xk; } event_t;
  event_t evq[$];

  always @(negedge clk) begin
    if (key_valid === 1'b1 || frame_err === 1'b1) begin
      check("pulse_exclusive", 32'(key_valid & frame_err), 32'd0);
      evq.push_back('{cyc: cyc, kv: key_valid, fe: frame_err, xk: xkey});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic d, input bit glitch, output int fall_cyc);
    ps2_data = d;
    if (glitch) begin
      tick(3); ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1; tick(HALF - 5);
    end else begin
      tick(HALF);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    tick(HALF);
    ps2_clk  = 1'b1;
  endtask

  // Transmission order: index 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (bad_par) p = ~p;
    return {logic'(!bad_stop), p, b, 1'b0};
  endfunction

  function automatic bit frame_good(input logic [10:0] f);
    return ($countones(f[9:1]) % 2 == 1) && (f[10] == 1'b1) && (f[0] == 1'b0);
  endfunction

  task automatic expect_frame(input string name, input int stop_cyc, input bit exp_kv,
                              input logic [15:0] exp_xk);
    event_t e;
    check({name, "_events"}, 32'(evq.size()), 32'd1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({name, "_latency"}, 32'(e.cyc - stop_cyc), 32'(LAT));
      check({name, "_key_valid"}, 32'(e.kv), 32'(exp_kv));
      check({name, "_frame_err"}, 32'(e.fe), 32'(!exp_kv));
      check({name, "_xkey_at_pulse"}, 32'(e.xk), 32'(exp_xk));
    end
    evq.delete();
    check({name, "_xkey_hold"}, 32'(xkey), 32'(exp_xk));
  endtask

  task automatic frame_and_check(input string name, input logic [7:0] b, input bit bad_par,
                                 input bit bad_stop, input bit glitch, input bit exp_kv,
                                 input logic [15:0] exp_xk);
    logic [10:0] f;
    int          fc;
    f = make_frame(b, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) send_bit(f[i], glitch && (i == 4), fc);
    ps2_data = 1'b1;
    tick(4);
    expect_frame(name, fc, exp_kv, exp_xk);
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          bad_stop;
    bit          glitch;
    bit          exp_kv;
    logic [15:0] exp_xk;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] model_xk;

  initial begin
    logic [10:0] f;
    logic [7:0]  rb;
    int          r, fc;
    bit          ok;
    logic [15:0] exp_xk;

    vecs[0] = '{SC_LEFT,     1'b0, 1'b0, 1'b0, 1'b1, 16'h006B};
    vecs[1] = '{SC_LEFT,     1'b0, 1'b0, 1'b0, 1'b1, 16'h6B6B};
    vecs[2] = '{SC_BREAK,    1'b0, 1'b0, 1'b0, 1'b1, 16'h6BF0};
    vecs[3] = '{SC_SPACE,    1'b0, 1'b0, 1'b0, 1'b1, 16'hF029};
    vecs[4] = '{SC_UP,       1'b1, 1'b0, 1'b0, 1'b0, 16'hF029};
    vecs[5] = '{SC_ENTER,    1'b0, 1'b0, 1'b0, 1'b1, 16'h295A};
    vecs[6] = '{SC_EXTENDED, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5AE0};
    vecs[7] = '{SC_RIGHT,    1'b0, 1'b1, 1'b0, 1'b0, 16'h5AE0};
    vecs[8] = '{SC_RIGHT,    1'b0, 1'b0, 1'b0, 1'b1, 16'hE074};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    check("reset_xkey", 32'(xkey), 32'd0);
    check("reset_key_valid", 32'(key_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick(5);
    check("post_reset_xkey", 32'(xkey), 32'd0);

    // A clock pulse with data high is not a start bit.
    ps2_data = 1'b1; tick(HALF); ps2_clk = 1'b0; tick(HALF); ps2_clk = 1'b1; tick(3 * HALF);
    check("idle_high_no_event", 32'(evq.size()), 32'd0);
    evq.delete();

    for (int i = 0; i < 9; i++) begin
      frame_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop,
                      vecs[i].glitch, vecs[i].exp_kv, vecs[i].exp_xk);
    end
    model_xk = 16'hE074;

    for (int i = 0; i < 30; i++) begin
      rb = 8'($urandom_range(0, 255));
      r  = int'($urandom_range(0, 9));
      f  = make_frame(rb, r == 0, r == 1);
      ok = frame_good(f);
      exp_xk = ok ? {model_xk[7:0], rb} : model_xk;
      frame_and_check($sformatf("rand%0d", i), rb, r == 0, r == 1, 1'b0, ok, exp_xk);
      model_xk = exp_xk;
    end

    // Stall after five bits (start + four data bits) of a 74 frame.
    f = make_frame(SC_RIGHT, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0, fc);
    tick(150);
`ifdef PS2_TIMEOUT_EN
    check("timeout_events", 32'(evq.size()), 32'd1);
    if (evq.size() > 0) begin
      check("timeout_frame_err", 32'(evq[0].fe), 32'd1);
      check("timeout_key_valid", 32'(evq[0].kv), 32'd0);
    end
    evq.delete();
    check("timeout_xkey_hold", 32'(xkey), 32'(model_xk));
    ps2_data = 1'b1;
    tick(HALF);
    exp_xk = {model_xk[7:0], SC_RIGHT};
    frame_and_check("after_timeout", SC_RIGHT, 1'b0, 1'b0, 1'b0, 1'b1, exp_xk);
    model_xk = exp_xk;
`else
    check("stall_no_event", 32'(evq.size()), 32'd0);
    for (int i = 5; i < 11; i++) send_bit(f[i], 1'b0, fc);
    ps2_data = 1'b1;
    tick(4);
    exp_xk = {model_xk[7:0], SC_RIGHT};
    expect_frame("stall_resume", fc, 1'b1, exp_xk);
    model_xk = exp_xk;
`endif

    // Reset after the fourth bit discards the partial frame silently.
    f = make_frame(SC_LEFT, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(f[i], 1'b0, fc);
    rst = 1'b1; tick(1); rst = 1'b0;
    ps2_data = 1'b1;
    tick(3 * HALF);
    check("midframe_reset_xkey", 32'(xkey), 32'd0);
    check("midframe_reset_no_event", 32'(evq.size()), 32'd0);
    evq.delete();
    model_xk = 16'h0000;
    frame_and_check("after_reset", SC_EXTENDED, 1'b0, 1'b0, 1'b0, 1'b1, {model_xk[7:0], SC_EXTENDED});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
